joy_serial_reader: RTL and testbench

- Parametrised serial joystick/JAMMA input reader that drives the external parallel-load shift-register chain (load, clock) and deserialises its data line into a flat, active-low button vector.
- Generalises the fixed two-player, 24-bit, free-running scanner to N players × M bits, with a configurable clock rate, lead-in skip, enable/park control, a frame strobe and change detection.
- Sits in each arcade top level between the JOY_CLK/JOY_LOAD/JOY_DATA pins and the per-core button remapping.

---
 rtl/joy_serial_reader.sv | 215 +++++++++++++++++++++
 tb/tb_joy_serial_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
`default_nettype none
// ============================================================================
// Module      : joy_serial_reader
// Description : Drives an external parallel-load shift-register chain
//               (joy_load_o / joy_clk_o) and deserialises its data line into
//               a flat, active-low button vector with a frame strobe and a
//               change flag.
// Options     : JOY_DEBOUNCE_EN - when defined, a frame is committed only if
//               it equals the previously captured frame (shadow register).
// Revision    : 1.0 - initial release
// ============================================================================
module joy_serial_reader #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int SKIP_BITS       = 1,
    parameter int CLK_DIV         = 8
) (
    input  logic                                   clk12,
    input  logic                                   pll_lckd,
    input  logic                                   en,
    input  logic                                   joy_data_i,
    output logic                                   joy_clk_o,
    output logic                                   joy_load_o,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joy_o,
    output logic                                   frame_valid_o,
    output logic                                   changed_o
);

    localparam int c_N     = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_N - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [3:0]         c_SKIP_NUM = 4'(SKIP_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SKIP   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic               r_joy_clk;
    logic [1:0]         r_sync;
    logic [3:0]         r_skip_cnt;
    logic [3:0]         w_skip_nxt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [c_N-1:0]     r_shift;
    logic [c_N-1:0]     r_joy;
    logic               r_load_n;
    logic               r_frame_valid;
    logic               r_changed;
    logic               w_tick;
    logic               w_capture;
    logic               w_commit;
    logic               w_accept;

    // A tick is the cycle in which the divided shift clock rises.
    assign w_tick   = (r_div == c_DIV_LAST) && !r_joy_clk;
    assign w_commit = (r_state == ST_COMMIT);

    // Free-running divider producing the chain shift clock.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_div     <= '0;
            r_joy_clk <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div     <= '0;
            r_joy_clk <= ~r_joy_clk;
        end else begin
            r_div     <= r_div + c_DIV_ONE;
        end
    end

    // Two-flop synchroniser for the asynchronous chain data line.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], joy_data_i};
        end
    end

    // Next-state logic: each tick ends one chain period and samples the data
    // shown during it. The tick leaving LOAD already sees the first chain bit,
    // so it is the first discarded bit (or the first captured bit when no
    // bits are skipped); the capture that ends the skip run happens in SKIP.
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_tick) begin
                    w_bit_nxt = '0;
                    if (SKIP_BITS > 0) begin
                        w_skip_nxt  = 4'd1;
                        w_state_nxt = ST_SKIP;
                    end else begin
                        w_capture   = 1'b1;
                        w_bit_nxt   = c_BIT_ONE;
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SKIP: begin
                if (w_tick) begin
                    if (r_skip_cnt == c_SKIP_NUM) begin
                        w_capture   = 1'b1;
                        w_bit_nxt   = c_BIT_ONE;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_skip_nxt  = r_skip_cnt + 4'd1;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    w_capture = 1'b1;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + c_BIT_ONE;
                    end
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; load strobe is registered to stay glitch-free.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
            r_bit_cnt  <= '0;
            r_load_n   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_load_n   <= (w_state_nxt != ST_LOAD);
        end
    end

    // Shift register, first captured bit ends up in the MSB.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_shift <= '1;
        end else if (w_capture) begin
            r_shift <= {r_shift[c_N-2:0], r_sync[1]};
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [c_N-1:0] r_shadow;

    // Shadow holds the last captured frame; only a repeat is accepted.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_shadow <= '1;
        end else if (w_commit) begin
            r_shadow <= r_shift;
        end
    end

    assign w_accept = (r_shift == r_shadow);
`else
    assign w_accept = 1'b1;
`endif

    // Commit the completed frame to the output together with its strobes.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            r_joy         <= '1;
            r_frame_valid <= 1'b0;
            r_changed     <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_changed     <= 1'b0;
            if (w_commit && w_accept) begin
                r_joy         <= r_shift;
                r_frame_valid <= 1'b1;
                r_changed     <= (r_shift != r_joy);
            end
        end
    end

    assign joy_clk_o     = r_joy_clk;
    assign joy_load_o    = r_load_n;
    assign joy_o         = r_joy;
    assign frame_valid_o = r_frame_valid;
    assign changed_o     = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_joy_serial_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_joy_serial_reader
// Description : Self-checking bench for joy_serial_reader. Two instances:
//               defaults (A) and 3x8 / no skip / CLK_DIV=3 (B), each fed by
//               a behavioural chain model and checked against a frame-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_serial_reader;

    localparam int A_PER  = (1 + 1 + 24) * 2 * 8;   // frame period, cycles
    localparam int A_FV   = (1 + 24) * 2 * 8 + 1;   // load start -> commit
    localparam int A_LOAD = 2 * 8;
    localparam int B_PER  = (1 + 0 + 24) * 2 * 3;
    localparam int B_FV   = (0 + 24) * 2 * 3 + 1;
    localparam int B_LOAD = 2 * 3;

    logic clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    logic        a_rst_n, a_en, a_data, a_jclk, a_load, a_fv, a_ch;
    logic [23:0] a_joy, a_pat;
    logic        b_rst_n, b_en, b_data, b_jclk, b_load, b_fv, b_ch;
    logic [23:0] b_joy, b_pat;
    int          a_idx = 0, b_idx = 0;
    logic        a_jprev = 1'b0, b_jprev = 1'b0;
    logic [23:0] a_mjoy, a_msh;
    int          n_vec = 0, n_err = 0;

    joy_serial_reader u_a (
        .clk12(clk12), .pll_lckd(a_rst_n), .en(a_en), .joy_data_i(a_data),
        .joy_clk_o(a_jclk), .joy_load_o(a_load), .joy_o(a_joy),
        .frame_valid_o(a_fv), .changed_o(a_ch)
    );

    joy_serial_reader #(
        .NUM_PLAYERS(3), .BITS_PER_PLAYER(8), .SKIP_BITS(0), .CLK_DIV(3)
    ) u_b (
        .clk12(clk12), .pll_lckd(b_rst_n), .en(b_en), .joy_data_i(b_data),
        .joy_clk_o(b_jclk), .joy_load_o(b_load), .joy_o(b_joy),
        .frame_valid_o(b_fv), .changed_o(b_ch)
    );

    // Chain A: index 0 (shown while loading) is a junk skip bit, then MSB first.
    always @(posedge clk12) begin
        #2;
        if (!a_load) a_idx = 0;
        else if (a_jclk && !a_jprev) a_idx = a_idx + 1;
        a_jprev = a_jclk;
        if (a_idx == 0) a_data = 1'($urandom_range(0, 1));
        else if (a_idx <= 24) a_data = a_pat[24 - a_idx];
        else a_data = 1'b1;
    end

    // Chain B: no skip bit, MSB shown while loading.
    always @(posedge clk12) begin
        #2;
        if (!b_load) b_idx = 0;
        else if (b_jclk && !b_jprev) b_idx = b_idx + 1;
        b_jprev = b_jclk;
        if (b_idx < 24) b_data = b_pat[23 - b_idx];
        else b_data = 1'b1;
    end

    // Reference: what a captured frame does to the committed output.
    task automatic ref_frame(input logic [23:0] p, inout logic [23:0] mjoy,
                             inout logic [23:0] msh, output bit commit, output bit ch);
`ifdef JOY_DEBOUNCE_EN
        commit = (p == msh);
        msh    = p;
`else
        commit = 1'b1;
`endif
        ch = 1'b0;
        if (commit) begin
            ch   = (p != mjoy);
            mjoy = p;
        end
    endtask

    // Runs one frame from a load-start sample to the next load start.
    task automatic run_frame(input bit sel, input logic [23:0] p, output int nfv,
                             output logic [23:0] vjoy, output logic vch, output int fvc,
                             output logic [23:0] prejoy, output int nload,
                             output int period, output bit tmo);
        logic        prev_load, ld;
        logic [23:0] last_joy;
        nfv = 0; vjoy = '0; vch = 1'b0; fvc = -1; nload = 1; period = 0; tmo = 1'b0;
        if (sel) b_pat = p; else a_pat = p;
        prev_load = 1'b0;
        last_joy  = sel ? b_joy : a_joy;
        prejoy    = last_joy;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk12); #1;
            ld = sel ? b_load : a_load;
            if (!ld && prev_load) begin
                period = c;
                return;
            end
            if (!ld && c == nload) nload++;
            if (sel ? b_fv : a_fv) begin
                nfv++;
                vjoy   = sel ? b_joy : a_joy;
                vch    = sel ? b_ch : a_ch;
                fvc    = c;
                prejoy = last_joy;
            end
            last_joy  = sel ? b_joy : a_joy;
            prev_load = ld;
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk12);
        #1;
        n_vec++; if (a_joy !== 24'hFFFFFF) begin n_err++; $display("FAIL rst_joy: got %h want ffffff", a_joy); end
        n_vec++; if (a_fv !== 1'b0) begin n_err++; $display("FAIL rst_fv: got %b want 0", a_fv); end
        n_vec++; if (a_ch !== 1'b0) begin n_err++; $display("FAIL rst_ch: got %b want 0", a_ch); end
        n_vec++; if (a_jclk !== 1'b0) begin n_err++; $display("FAIL rst_jclk: got %b want 0", a_jclk); end
        n_vec++; if (a_load !== 1'b1) begin n_err++; $display("FAIL rst_load: got %b want 1", a_load); end
        n_vec++; if (b_joy !== 24'hFFFFFF) begin n_err++; $display("FAIL rst_b_joy: got %h want ffffff", b_joy); end
    endtask

    task automatic test_first_load();
        int n;
        @(negedge clk12);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk12); #1; n++; end while (a_load !== 1'b0 && n < 100);
        n_vec++; if (n !== 8) begin n_err++; $display("FAIL first_load_at: got %0d cycles want 8", n); end
        n_vec++; if (a_joy !== 24'hFFFFFF) begin n_err++; $display("FAIL first_load_joy: got %h want ffffff", a_joy); end
    endtask

    task automatic test_pattern_frames();
        logic [23:0] p, vjoy, prejoy, old;
        logic        vch;
        bit          cm, ch, tmo;
        int          nfv, fvc, nload, per;
        p = 24'hFFFFFF;
        for (int k = 0; k < 11; k++) begin
            if (k == 0) p = 24'hFFFFFF;
            else if (k <= 2) p = 24'hA5F00F;
            else if ((k % 2) == 1) p = 24'($urandom);
            old = a_mjoy;
            run_frame(1'b0, p, nfv, vjoy, vch, fvc, prejoy, nload, per, tmo);
            ref_frame(p, a_mjoy, a_msh, cm, ch);
            n_vec++; if (tmo) begin n_err++; $display("FAIL frame_timeout: frame %0d no next load", k); end
            n_vec++; if (per !== A_PER) begin n_err++; $display("FAIL frame_period: got %0d want %0d", per, A_PER); end
            n_vec++; if (nload !== A_LOAD) begin n_err++; $display("FAIL load_width: got %0d want %0d", nload, A_LOAD); end
            n_vec++; if (nfv !== (cm ? 1 : 0)) begin n_err++; $display("FAIL fv_count: frame %0d got %0d want %0d", k, nfv, cm ? 1 : 0); end
            if (cm) begin
                n_vec++; if (vjoy !== p) begin n_err++; $display("FAIL frame_joy: got %h want %h", vjoy, p); end
                n_vec++; if (vch !== ch) begin n_err++; $display("FAIL frame_changed: got %b want %b", vch, ch); end
                n_vec++; if (fvc !== A_FV) begin n_err++; $display("FAIL fv_latency: got %0d want %0d", fvc, A_FV); end
                n_vec++; if (prejoy !== old) begin n_err++; $display("FAIL joy_early: got %h want %h", prejoy, old); end
            end
            n_vec++; if (a_joy !== a_mjoy) begin n_err++; $display("FAIL joy_hold: got %h want %h", a_joy, a_mjoy); end
        end
    endtask

    task automatic test_en_drop();
        logic [23:0] p, vjoy, prejoy;
        logic        vch, jp;
        bit          cm, ch, tmo, seen;
        int          nfv, fvc, nload, per, r, bad_fv, bad_ld, c;
        p = 24'($urandom);
        run_frame(1'b0, p, nfv, vjoy, vch, fvc, prejoy, nload, per, tmo);
        ref_frame(p, a_mjoy, a_msh, cm, ch);
        ref_frame(p, a_mjoy, a_msh, cm, ch);
        a_pat = p;
        jp = a_jclk;
        r = 0;
        for (int i = 0; i < 2000 && r < 12; i++) begin
            @(posedge clk12); #1;
            if (a_jclk && !jp) r++;
            jp = a_jclk;
        end
        a_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clk12); #1;
            if (a_fv) begin seen = 1'b1; vjoy = a_joy; vch = a_ch; end
        end
        n_vec++; if (seen !== cm) begin n_err++; $display("FAIL endrop_commit: got %b want %b", seen, cm); end
        n_vec++; if (vjoy !== p) begin n_err++; $display("FAIL endrop_joy: got %h want %h", vjoy, p); end
        n_vec++; if (vch !== ch) begin n_err++; $display("FAIL endrop_changed: got %b want %b", vch, ch); end
        bad_fv = 0; bad_ld = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk12); #1;
            if (a_fv) bad_fv++;
            if (!a_load) bad_ld++;
        end
        n_vec++; if (bad_fv !== 0) begin n_err++; $display("FAIL parked_fv: got %0d pulses want 0", bad_fv); end
        n_vec++; if (bad_ld !== 0) begin n_err++; $display("FAIL parked_load: got %0d low cycles want 0", bad_ld); end
        repeat ($urandom_range(0, 20)) @(posedge clk12);
        #1;
        jp = a_jclk;
        a_en = 1'b1;
        c = 0;
        do begin
            jp = a_jclk;
            @(posedge clk12); #1; c++;
        end while (a_load !== 1'b0 && c < 100);
        n_vec++; if (c > A_LOAD) begin n_err++; $display("FAIL restart_delay: got %0d cycles want <= %0d", c, A_LOAD); end
        n_vec++; if (!(a_jclk && !jp)) begin n_err++; $display("FAIL restart_on_tick: got jclk %b prev %b want 1/0", a_jclk, jp); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] vjoy, prejoy;
        logic        vch, jp;
        bit          cm, ch, tmo;
        int          nfv, fvc, nload, per, r, n, fvs;
        a_pat = 24'h000000;
        jp = a_jclk;
        r = 0;
        for (int i = 0; i < 2000 && r < 14; i++) begin
            @(posedge clk12); #1;
            if (a_jclk && !jp) r++;
            jp = a_jclk;
        end
        #3;
        a_rst_n = 1'b0;
        #1;
        a_mjoy = 24'hFFFFFF;
        a_msh  = 24'hFFFFFF;
        n_vec++; if (a_joy !== 24'hFFFFFF) begin n_err++; $display("FAIL midrst_joy: got %h want ffffff", a_joy); end
        n_vec++; if (a_fv !== 1'b0) begin n_err++; $display("FAIL midrst_fv: got %b want 0", a_fv); end
        n_vec++; if (a_load !== 1'b1) begin n_err++; $display("FAIL midrst_load: got %b want 1", a_load); end
        n_vec++; if (a_jclk !== 1'b0) begin n_err++; $display("FAIL midrst_jclk: got %b want 0", a_jclk); end
        @(posedge clk12); @(posedge clk12); @(negedge clk12);
        a_rst_n = 1'b1;
        n = 0; fvs = 0;
        do begin @(posedge clk12); #1; n++; if (a_fv) fvs++; end while (a_load !== 1'b0 && n < 100);
        n_vec++; if (n !== 8) begin n_err++; $display("FAIL midrst_reload: got %0d cycles want 8", n); end
        n_vec++; if (fvs !== 0) begin n_err++; $display("FAIL midrst_partial: got %0d commits want 0", fvs); end
        run_frame(1'b0, 24'h000000, nfv, vjoy, vch, fvc, prejoy, nload, per, tmo);
        ref_frame(24'h000000, a_mjoy, a_msh, cm, ch);
        n_vec++; if (nfv !== (cm ? 1 : 0)) begin n_err++; $display("FAIL midrst_fv_count: got %0d want %0d", nfv, cm ? 1 : 0); end
        n_vec++; if (a_joy !== a_mjoy) begin n_err++; $display("FAIL midrst_joy_after: got %h want %h", a_joy, a_mjoy); end
    endtask

`ifdef JOY_DEBOUNCE_EN
    task automatic test_debounce();
        logic [23:0] seq_p [6];
        logic [23:0] vjoy, prejoy;
        logic        vch;
        bit          cm, ch, tmo;
        int          nfv, fvc, nload, per;
        seq_p = '{24'h000001, 24'h000002, 24'h000001, 24'h000002, 24'h000003, 24'h000003};
        for (int k = 0; k < 6; k++) begin
            run_frame(1'b0, seq_p[k], nfv, vjoy, vch, fvc, prejoy, nload, per, tmo);
            ref_frame(seq_p[k], a_mjoy, a_msh, cm, ch);
            n_vec++; if (nfv !== (cm ? 1 : 0)) begin n_err++; $display("FAIL deb_fv: frame %0d got %0d want %0d", k, nfv, cm ? 1 : 0); end
            if (cm) begin
                n_vec++; if (vjoy !== seq_p[k]) begin n_err++; $display("FAIL deb_joy: got %h want %h", vjoy, seq_p[k]); end
                n_vec++; if (vch !== ch) begin n_err++; $display("FAIL deb_changed: got %b want %b", vch, ch); end
            end
            if (k == 3) begin
                n_vec++; if (a_joy !== 24'hFFFFFF) begin n_err++; $display("FAIL deb_hold: got %h want ffffff", a_joy); end
            end
        end
    endtask
`endif

    task automatic test_alt_config();
        logic [23:0] p, mj, ms, vjoy, prejoy, old;
        logic        vch;
        bit          cm, ch, tmo;
        int          nfv, fvc, nload, per, c;
        mj = 24'hFFFFFF; ms = 24'hFFFFFF;
        p = 24'h123456;
        b_en = 1'b1;
        c = 0;
        do begin @(posedge clk12); #1; c++; end while (b_load !== 1'b0 && c < 100);
        n_vec++; if (b_load !== 1'b0) begin n_err++; $display("FAIL b_start: got load %b want 0", b_load); end
        for (int k = 0; k < 6; k++) begin
            if (k < 2) p = 24'h123456;
            else if ((k % 2) == 0) p = 24'($urandom);
            old = mj;
            run_frame(1'b1, p, nfv, vjoy, vch, fvc, prejoy, nload, per, tmo);
            ref_frame(p, mj, ms, cm, ch);
            n_vec++; if (tmo) begin n_err++; $display("FAIL b_timeout: frame %0d no next load", k); end
            n_vec++; if (per !== B_PER) begin n_err++; $display("FAIL b_period: got %0d want %0d", per, B_PER); end
            n_vec++; if (nload !== B_LOAD) begin n_err++; $display("FAIL b_load_width: got %0d want %0d", nload, B_LOAD); end
            n_vec++; if (nfv !== (cm ? 1 : 0)) begin n_err++; $display("FAIL b_fv_count: got %0d want %0d", nfv, cm ? 1 : 0); end
            if (cm) begin
                n_vec++; if (vjoy !== p) begin n_err++; $display("FAIL b_joy: got %h want %h", vjoy, p); end
                n_vec++; if (vch !== ch) begin n_err++; $display("FAIL b_changed: got %b want %b", vch, ch); end
                n_vec++; if (fvc !== B_FV) begin n_err++; $display("FAIL b_fv_latency: got %0d want %0d", fvc, B_FV); end
                n_vec++; if (prejoy !== old) begin n_err++; $display("FAIL b_joy_early: got %h want %h", prejoy, old); end
            end
        end
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_en = 1'b1;    b_en = 1'b0;
        a_data = 1'b1;  b_data = 1'b1;
        a_pat = 24'hFFFFFF; b_pat = 24'hFFFFFF;
        a_mjoy = 24'hFFFFFF; a_msh = 24'hFFFFFF;
        test_reset();
        test_first_load();
        test_pattern_frames();
        test_en_drop();
        test_reset_midframe();
`ifdef JOY_DEBOUNCE_EN
        test_debounce();
`endif
        test_alt_config();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
